// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset PC and the {pc, inst}
// fetch entry passed from prefetch to IF/ID.
package cpu_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous DEPTH-entry queue of fetch entries with flush, push, pop
// and occupancy count; no bypass path.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue between the 1-cycle ROM and IF.
// Optional same-cycle ROM-to-IF bypass when PREFETCH_BYPASS_EN is defined.
module inst_prefetch_buf
    import cpu_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        redirect_valid,
    input  logic [PC_W-1:0]             redirect_pc,
    output logic [PC_W-1:0]             rom_addr,
    input  logic [INST_W-1:0]           rom_data,
    output logic                        out_valid,
    output logic [PC_W-1:0]             out_pc,
    output logic [INST_W-1:0]           out_inst,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CW      = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;

    logic            issue;
    logic            pop;
    logic            push;
    logic            fifo_pop;
    logic            bypass;
    logic [CW:0]     occupancy;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_count)
    );

    always_comb begin
        push_entry = '{pc: inflight_pc_q, inst: rom_data};
`ifdef PREFETCH_BYPASS_EN
        bypass = inflight_q & ~redirect_valid & (fifo_count == '0);
`else
        bypass = 1'b0;
`endif
        out_valid = ((fifo_count != '0) | bypass) & ~redirect_valid;
        out_pc    = bypass ? inflight_pc_q : head.pc;
        out_inst  = bypass ? rom_data : head.inst;
        pop       = out_valid & out_ready;
        // A bypassed word taken by IF never enters the queue.
        push      = inflight_q & ~redirect_valid & ~(bypass & out_ready);
        fifo_pop  = pop & ~bypass;
        occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        issue     = resetn & ~redirect_valid
                  & ((occupancy < DEPTH_C) | pop);
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + PC_W'(4);
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign rom_addr = {fetch_pc_q[PC_W-1:2], 2'b00};
    assign count    = fifo_count;

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed-vector bench for inst_prefetch_buf (default build, DEPTH=4,
// RESET_PC=0) with a behavioural 1-cycle ROM.
module tb_inst_prefetch_buf;

    typedef struct {
        logic        rstn;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic [31:0] eaddr;
    } vec_t;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic [2:0]  count;

    int n_chk;
    int n_fail;
    vec_t vecs[$];

    inst_prefetch_buf dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ready      (out_ready),
        .count          (count)
    );

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_F00D;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic rd,
                       input logic [31:0] rp, input logic ry,
                       input logic ev, input logic [31:0] ep,
                       input logic [2:0] ec, input logic [31:0] ea);
        vec_t v;
        v.rstn = rs; v.redir = rd; v.rpc = rp; v.rdy = ry;
        v.ev = ev; v.epc = ep; v.ecnt = ec; v.eaddr = ea;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          hs;
        bit          full;

        n_chk = 0;
        n_fail = 0;
        clk = 1'b0;
        resetn = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;

        // reset state, then fill under backpressure
        add(0, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 0, 0, 0, 32'h4);
        add(1, 0, 0, 0, 1, 32'h0, 1, 32'h8);
        add(1, 0, 0, 0, 1, 32'h0, 2, 32'hC);
        add(1, 0, 0, 0, 1, 32'h0, 3, 32'h10);
        for (int k = 0; k < 5; k++)
            add(1, 0, 0, 0, 1, 32'h0, 4, 32'h10);
        // drain in order at 1/cycle
        add(1, 0, 0, 1, 1, 32'h0, 4, 32'h10);
        for (int k = 1; k <= 7; k++)
            add(1, 0, 0, 1, 1, 32'(4*k), 3, 32'(16 + 4*k));
        // redirect to 0x100, then redirect again with count=2, inflight=1
        add(1, 1, 32'h100, 1, 0, 0, 3, 32'h30);
        add(1, 0, 0, 0, 0, 0, 0, 32'h100);
        add(1, 0, 0, 0, 0, 0, 0, 32'h104);
        add(1, 0, 0, 0, 1, 32'h100, 1, 32'h108);
        add(1, 1, 32'h40, 0, 0, 0, 2, 32'h10C);
        add(1, 0, 0, 1, 0, 0, 0, 32'h40);
        add(1, 0, 0, 1, 0, 0, 0, 32'h44);
        add(1, 0, 0, 1, 1, 32'h40, 1, 32'h48);
        add(1, 0, 0, 1, 1, 32'h44, 1, 32'h4C);
        add(1, 0, 0, 1, 1, 32'h48, 1, 32'h50);
        // build count=3, then redirect with out_ready=1, unaligned target
        add(1, 0, 0, 0, 1, 32'h4C, 1, 32'h54);
        add(1, 0, 0, 0, 1, 32'h4C, 2, 32'h58);
        add(1, 1, 32'h43, 1, 0, 0, 3, 32'h5C);
        add(1, 0, 0, 1, 0, 0, 0, 32'h40);
        add(1, 0, 0, 1, 0, 0, 0, 32'h44);
        add(1, 0, 0, 1, 1, 32'h40, 1, 32'h48);
        add(1, 0, 0, 1, 1, 32'h44, 1, 32'h4C);
        // address wrap
        add(1, 1, 32'hFFFF_FFF8, 1, 0, 0, 1, 32'h50);
        add(1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8);
        add(1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        add(1, 0, 0, 1, 1, 32'hFFFF_FFF8, 1, 32'h0);
        add(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h4);
        add(1, 0, 0, 1, 1, 32'h0, 1, 32'h8);
        add(1, 0, 0, 1, 1, 32'h4, 1, 32'hC);
        // reset mid-operation, then restart latency
        add(0, 0, 0, 1, 1, 32'h8, 1, 32'h10);
        add(0, 0, 0, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 1, 0, 0, 0, 32'h0);
        add(1, 0, 0, 1, 0, 0, 0, 32'h4);
        add(1, 0, 0, 1, 1, 32'h0, 1, 32'h8);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            resetn = vecs[i].rstn;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            out_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid),
                32'(vecs[i].ev));
            chk($sformatf("v%0d count", i), 32'(count),
                32'(vecs[i].ecnt));
            chk($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("v%0d out_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("v%0d out_inst", i), out_inst,
                    rom_f(vecs[i].epc));
            end
        end

        // head is 0x4 after the last vector's handshake; fill to DEPTH
        exp_pc = 32'h4;
        full = 1'b0;
        for (int c = 0; c < 20 && !full; c++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            out_ready = 1'b0;
            #1;
            full = (count == 3'd4);
        end
        chk("full reached", 32'(full), 32'd1);
        chk("full rom_addr hold", rom_addr, 32'h14);

        // toggle out_ready at full: push and pop overlap
        hs = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            out_ready = (c % 2 == 0);
            #1;
            chk($sformatf("toggle%0d count range", c),
                32'(count >= 3'd3 && count <= 3'd4), 32'd1);
            if (out_valid && out_ready) begin
                chk($sformatf("toggle%0d out_pc", c), out_pc, exp_pc);
                chk($sformatf("toggle%0d out_inst", c), out_inst,
                    rom_f(exp_pc));
                exp_pc += 32'h4;
                hs++;
            end
        end
        chk("toggle handshakes", 32'(hs), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
